// File: rtl/servo_pkg.sv
// Shared servo link timing defaults and the decoder state encoding.
// Used by the servo driver, the angle decoder and the PWM receive path.
package servo_pkg;
    localparam int MIN_PULSE      = 50000;
    localparam int CYCLES_PER_DEG = 1000;
    localparam int MAX_ANGLE      = 180;
    localparam int FRAME_CYCLES   = 2000000;
    localparam int FRAME_TOL      = 100000;
    localparam int TIMEOUT_CYCLES = 3000000;
    localparam int SETTLE_FRAMES  = 3;

    localparam int ANGLE_W  = 9;
    localparam int PW_W     = 20;
    localparam int PERIOD_W = 22;
    localparam int STABLE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        DIV,
        LOW
    } state_e;
endpackage

// File: rtl/servo_pwm_decoder_if.sv
// PWM line in, decoded angle/status out, for the servo PWM receiver.
interface servo_pwm_decoder_if;
    import servo_pkg::*;

    logic                pwm_in;
    logic [ANGLE_W-1:0]  angle;
    logic                angle_valid;
    logic [PW_W-1:0]     pulse_width;
    logic                err_range;
    logic                err_period;
    logic                signal_lost;
    logic                settled;

    modport slave (
        input  pwm_in,
        output angle, angle_valid, pulse_width, err_range, err_period, signal_lost, settled
    );

    modport master (
        output pwm_in,
        input  angle, angle_valid, pulse_width, err_range, err_period, signal_lost, settled
    );
endinterface

// File: rtl/servo_pwm_decoder_edge_sync.sv
// Two-flop synchronizer with registered rise/fall strobes, three cycles after the pin edge.
// Strobes stay off until the line has been seen low, so a line high at reset exit is not a rise.
module pwm_edge_sync (
    input  logic clk,
    input  logic clr,
    input  logic async_in,
    output logic rise,
    output logic fall
);
    logic       meta_q, meta_d;
    logic       sync_q, sync_d;
    logic       prev_q, prev_d;
    logic       armed_q, armed_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic [1:0] fill_q, fill_d;

    always_comb begin
        meta_d  = async_in;
        sync_d  = meta_q;
        prev_d  = sync_q;
        fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
        // prev_q only reflects the pin once the pipeline has refilled after clr
        armed_d = armed_q | ((fill_q == 2'd3) & ~prev_q);
        rise_d  = armed_q &  sync_q & ~prev_q;
        fall_d  = armed_q & ~sync_q &  prev_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            fill_q  <= 2'd0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            fill_q  <= fill_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures high time and frame period, divides pulse width back to degrees,
// and reports range/period errors, signal loss and angle stability.
module servo_pwm_decoder #(
    parameter int MIN_PULSE      = servo_pkg::MIN_PULSE,
    parameter int CYCLES_PER_DEG = servo_pkg::CYCLES_PER_DEG,
    parameter int MAX_ANGLE      = servo_pkg::MAX_ANGLE,
    parameter int FRAME_CYCLES   = servo_pkg::FRAME_CYCLES,
    parameter int FRAME_TOL      = servo_pkg::FRAME_TOL,
    parameter int TIMEOUT_CYCLES = servo_pkg::TIMEOUT_CYCLES,
    parameter int SETTLE_FRAMES  = servo_pkg::SETTLE_FRAMES
) (
    input  logic                clk,
    input  logic                clr,
    servo_pwm_decoder_if.slave  bus
);
    import servo_pkg::state_e;
    import servo_pkg::IDLE;
    import servo_pkg::HIGH;
    import servo_pkg::DIV;
    import servo_pkg::LOW;

    localparam int ANGLE_W  = servo_pkg::ANGLE_W;
    localparam int PW_W     = servo_pkg::PW_W;
    localparam int PERIOD_W = servo_pkg::PERIOD_W;
    localparam int STABLE_W = servo_pkg::STABLE_W;

    localparam logic [PW_W-1:0]     PW_ONE     = PW_W'(1);
    localparam logic [PW_W-1:0]     PW_MAX     = '1;
    localparam logic [PW_W-1:0]     MIN_W      = PW_W'(MIN_PULSE);
    localparam logic [PW_W-1:0]     MAX_W      = PW_W'(MIN_PULSE + MAX_ANGLE * CYCLES_PER_DEG);
    localparam logic [PW_W-1:0]     DEG_W      = PW_W'(CYCLES_PER_DEG);
    localparam logic [PERIOD_W-1:0] PER_ONE    = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] PER_MAX    = '1;
    localparam logic [PERIOD_W-1:0] PER_LO     = PERIOD_W'(FRAME_CYCLES - FRAME_TOL);
    localparam logic [PERIOD_W-1:0] PER_HI     = PERIOD_W'(FRAME_CYCLES + FRAME_TOL);
    localparam logic [PERIOD_W-1:0] TMO        = PERIOD_W'(TIMEOUT_CYCLES);
    localparam logic [STABLE_W-1:0] STABLE_ONE = STABLE_W'(1);
    localparam logic [STABLE_W-1:0] STABLE_MAX = '1;
    localparam logic [STABLE_W-1:0] SETTLE_N   = STABLE_W'(SETTLE_FRAMES);

    logic rise, fall;

    state_e              state_q, state_d;
    logic [PW_W-1:0]     high_cnt_q, high_cnt_d;
    logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
    logic [PW_W-1:0]     rem_q, rem_d;
    logic [ANGLE_W-1:0]  quot_q, quot_d;
    logic [ANGLE_W-1:0]  angle_q, angle_d;
    logic                angle_valid_q, angle_valid_d;
    logic [PW_W-1:0]     pulse_width_q, pulse_width_d;
    logic                err_range_q, err_range_d;
    logic                err_period_q, err_period_d;
    logic                signal_lost_q, signal_lost_d;
    logic                settled_q, settled_d;
    logic [STABLE_W-1:0] stable_cnt_q, stable_cnt_d;

    pwm_edge_sync u_sync (
        .clk      (clk),
        .clr      (clr),
        .async_in (bus.pwm_in),
        .rise     (rise),
        .fall     (fall)
    );

    always_comb begin
        state_d       = state_q;
        high_cnt_d    = high_cnt_q;
        period_cnt_d  = period_cnt_q;
        rem_d         = rem_q;
        quot_d        = quot_q;
        angle_d       = angle_q;
        angle_valid_d = 1'b0;
        pulse_width_d = pulse_width_q;
        err_range_d   = 1'b0;
        err_period_d  = 1'b0;
        signal_lost_d = signal_lost_q;
        settled_d     = settled_q;
        stable_cnt_d  = stable_cnt_q;

        if (state_q != IDLE && period_cnt_q != PER_MAX)
            period_cnt_d = period_cnt_q + 1'b1;
        if (state_q == HIGH && high_cnt_q != PW_MAX)
            high_cnt_d = high_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d      = HIGH;
                    high_cnt_d   = PW_ONE;
                    period_cnt_d = PER_ONE;
                end
            end
            HIGH: begin
                if (fall) begin
                    pulse_width_d = high_cnt_q;
                    if (high_cnt_q < MIN_W || high_cnt_q > MAX_W) begin
                        err_range_d = 1'b1;
                        state_d     = LOW;
                    end else begin
                        rem_d   = high_cnt_q - MIN_W;
                        quot_d  = '0;
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                // A rise here is a glitch: drop the divide and start a new frame
                if (rise) begin
                    err_range_d = 1'b1;
                    state_d     = HIGH;
                    high_cnt_d  = PW_ONE;
                end else if (rem_q >= DEG_W) begin
                    rem_d  = rem_q - DEG_W;
                    quot_d = quot_q + 1'b1;
                end else begin
                    angle_d       = quot_q;
                    angle_valid_d = 1'b1;
                    signal_lost_d = 1'b0;
                    state_d       = LOW;
                    if (quot_q == angle_q)
                        stable_cnt_d = (stable_cnt_q == STABLE_MAX) ? stable_cnt_q : stable_cnt_q + 1'b1;
                    else
                        stable_cnt_d = STABLE_ONE;
                    settled_d = (stable_cnt_d >= SETTLE_N);
                end
            end
            LOW: begin
                if (rise) begin
                    state_d    = HIGH;
                    high_cnt_d = PW_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outside IDLE every rise closes a measured period
        if (state_q != IDLE && rise) begin
            period_cnt_d = PER_ONE;
            if (period_cnt_q < PER_LO || period_cnt_q > PER_HI)
                err_period_d = 1'b1;
        end

        if (err_range_d || err_period_d) begin
            stable_cnt_d = '0;
            settled_d    = 1'b0;
        end

        if (state_q != IDLE && period_cnt_q >= TMO) begin
            state_d       = IDLE;
            high_cnt_d    = '0;
            period_cnt_d  = '0;
            angle_d       = angle_q;
            angle_valid_d = 1'b0;
            signal_lost_d = 1'b1;
            settled_d     = 1'b0;
            stable_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= IDLE;
            high_cnt_q    <= '0;
            period_cnt_q  <= '0;
            rem_q         <= '0;
            quot_q        <= '0;
            angle_q       <= '0;
            angle_valid_q <= 1'b0;
            pulse_width_q <= '0;
            err_range_q   <= 1'b0;
            err_period_q  <= 1'b0;
            signal_lost_q <= 1'b1;
            settled_q     <= 1'b0;
            stable_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            high_cnt_q    <= high_cnt_d;
            period_cnt_q  <= period_cnt_d;
            rem_q         <= rem_d;
            quot_q        <= quot_d;
            angle_q       <= angle_d;
            angle_valid_q <= angle_valid_d;
            pulse_width_q <= pulse_width_d;
            err_range_q   <= err_range_d;
            err_period_q  <= err_period_d;
            signal_lost_q <= signal_lost_d;
            settled_q     <= settled_d;
            stable_cnt_q  <= stable_cnt_d;
        end
    end

    assign bus.angle       = angle_q;
    assign bus.angle_valid = angle_valid_q;
    assign bus.pulse_width = pulse_width_q;
    assign bus.err_range   = err_range_q;
    assign bus.err_period  = err_period_q;
    assign bus.signal_lost = signal_lost_q;
    assign bus.settled     = settled_q;
endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Frame-level bench for servo_pwm_decoder with timing scaled down to keep runs short.
// Expected results come from a per-frame model of the decode, period and settle rules.
module tb_servo_pwm_decoder;
    localparam int MINP = 100;
    localparam int CPD  = 4;
    localparam int MAXA = 180;
    localparam int MAXP = MINP + MAXA * CPD;
    localparam int FR   = 2000;
    localparam int TOL  = 100;
    localparam int TMO  = 3000;
    localparam int SETN = 3;

    logic clk;
    logic clr;
    servo_pwm_decoder_if bus ();

    servo_pwm_decoder #(
        .MIN_PULSE      (MINP),
        .CYCLES_PER_DEG (CPD),
        .MAX_ANGLE      (MAXA),
        .FRAME_CYCLES   (FR),
        .FRAME_TOL      (TOL),
        .TIMEOUT_CYCLES (TMO),
        .SETTLE_FRAMES  (SETN)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // observed strobe history
    int tcyc = 0;
    int n_av = 0, n_er = 0, n_ep = 0;
    int av_cyc = -1, av_angle = -1, av_settled = -1, av_lost = -1;
    int lost_rise = -1;
    bit lost_prev = 1'b1;

    // reference model state
    bit m_have_prev = 1'b0;
    int m_prev_p = 0;
    int m_last_ang = 0;
    int m_stable = 0;
    bit m_settled = 1'b0;
    bit m_lost = 1'b1;
    int m_pending_er = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(negedge clk);
        tcyc++;
        if (bus.angle_valid) begin
            n_av++;
            av_cyc     = tcyc;
            av_angle   = int'(bus.angle);
            av_settled = int'(bus.settled);
            av_lost    = int'(bus.signal_lost);
        end
        if (bus.err_range)  n_er++;
        if (bus.err_period) n_ep++;
        if (bus.signal_lost && !lost_prev) lost_rise = tcyc;
        lost_prev = bus.signal_lost;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_angle"},  int'(bus.angle), 0);
        chk({tag, "_av"},     int'(bus.angle_valid), 0);
        chk({tag, "_pw"},     int'(bus.pulse_width), 0);
        chk({tag, "_er"},     int'(bus.err_range), 0);
        chk({tag, "_ep"},     int'(bus.err_period), 0);
        chk({tag, "_lost"},   int'(bus.signal_lost), 1);
        chk({tag, "_settle"}, int'(bus.settled), 0);
    endtask

    task automatic model_reset();
        m_have_prev  = 1'b0;
        m_prev_p     = 0;
        m_last_ang   = 0;
        m_stable     = 0;
        m_settled    = 1'b0;
        m_lost       = 1'b1;
        m_pending_er = 0;
    endtask

    // One frame: rise, w cycles high, then low until the next frame's rise (p cycles after
    // this rise). A glitch frame is cut short by a rise 10 cycles after the fall.
    task automatic frame(input int w, input int p, input bit glitch);
        int av0, er0, ep0, t0, ang, exp_er, exp_av, exp_ep;
        bit in_rng;
        av0 = n_av; er0 = n_er; ep0 = n_ep;

        exp_ep = (m_have_prev && (m_prev_p < FR - TOL || m_prev_p > FR + TOL)) ? 1 : 0;
        in_rng = (w >= MINP && w <= MAXP);
        exp_er = m_pending_er + ((!glitch && !in_rng) ? 1 : 0);
        exp_av = (!glitch && in_rng) ? 1 : 0;
        ang    = in_rng ? (w - MINP) / CPD : 0;

        if (exp_ep != 0 || m_pending_er != 0) begin
            m_stable = 0; m_settled = 1'b0;
        end
        if (exp_av != 0) begin
            m_stable   = (ang == m_last_ang) ? m_stable + 1 : 1;
            m_last_ang = ang;
            m_settled  = (m_stable >= SETN);
            m_lost     = 1'b0;
        end else if (!glitch) begin
            m_stable = 0; m_settled = 1'b0;
        end
        m_pending_er = glitch ? 1 : 0;
        m_have_prev  = 1'b1;
        m_prev_p     = glitch ? w + 10 : p;

        t0 = tcyc;
        lost_rise = -1;
        bus.pwm_in = 1'b1;
        repeat (w) step();
        bus.pwm_in = 1'b0;
        repeat (glitch ? 10 : p - w) step();

        chk("av_count", n_av - av0, exp_av);
        if (exp_av != 0) begin
            chk("angle", av_angle, ang);
            chk("av_latency", av_cyc - t0, w + 5 + ang);
            chk("av_settled", av_settled, int'(m_settled));
            chk("av_lost", av_lost, 0);
        end
        chk("err_range_count", n_er - er0, exp_er);
        chk("err_period_count", n_ep - ep0, exp_ep);
        chk("pulse_width", int'(bus.pulse_width), w);

        if (!glitch && p > TMO) begin
            chk("lost_rise_cycle", lost_rise - t0, TMO + 4);
            m_lost = 1'b1; m_settled = 1'b0; m_stable = 0; m_have_prev = 1'b0;
        end
        chk("settled_end", int'(bus.settled), int'(m_settled));
        chk("lost_end", int'(bus.signal_lost), int'(m_lost));
        $display("frame w=%0d p=%0d glitch=%0d angle=%0d av=%0d er=%0d ep=%0d settled=%0d lost=%0d",
                 w, p, glitch, av_angle, n_av - av0, n_er - er0, n_ep - ep0, bus.settled, bus.signal_lost);
    endtask

    initial begin
        int n0, w, p, last_w;
        clr = 1'b1;
        bus.pwm_in = 1'b0;
        repeat (4) step();
        chk_reset("reset");
        clr = 1'b0;
        repeat (10) step();

        // nominal 50 deg, settles on the third strobe
        repeat (3) frame(MINP + 50 * CPD, FR, 1'b0);

        // clr in the middle of a high pulse, released while the line is still high
        n0 = n_av + n_er + n_ep;
        bus.pwm_in = 1'b1;
        repeat (200) step();
        clr = 1'b1;
        step();
        chk_reset("clr");
        clr = 1'b0;
        repeat (100) step();
        bus.pwm_in = 1'b0;
        repeat (300) step();
        chk("clr_no_strobe", n_av + n_er + n_ep - n0, 0);
        chk("clr_lost", int'(bus.signal_lost), 1);
        $display("clr mid-high: strobes=%0d lost=%0d", n_av + n_er + n_ep - n0, bus.signal_lost);
        model_reset();

        // width boundaries and truncation
        frame(MINP, FR, 1'b0);
        frame(MAXP, FR, 1'b0);
        frame(MINP + CPD - 1, FR, 1'b0);
        frame(MINP - 1, FR, 1'b0);
        frame(MAXP + 1, FR, 1'b0);

        // period tolerance edges and a short frame
        frame(300, FR - TOL, 1'b0);
        frame(300, FR + TOL, 1'b0);
        frame(300, FR - TOL - 1, 1'b0);
        frame(300, FR + TOL + 1, 1'b0);
        frame(300, FR, 1'b0);
        frame(300, (FR * 3) / 4, 1'b0);
        frame(300, FR, 1'b0);

        // loss of signal, then recovery
        frame(300, TMO + 100, 1'b0);
        frame(300, FR, 1'b0);

        // glitch rise during the divide
        frame(MINP + 150 * CPD, 0, 1'b1);
        frame(300, FR, 1'b0);

        last_w = 300;
        for (int i = 0; i < 8; i++) begin
            w = ($urandom_range(1, 0) == 1) ? last_w : int'($urandom_range(860, 80));
            p = int'($urandom_range(2120, 1880));
            frame(w, p, 1'b0);
            last_w = w;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
